// File: rtl/difftest_arch_int_reg_tracker_if.sv
// Commit-side and snapshot-side bundle of the DiffTest integer register-state producer.
// The master modport is the tracker; the slave modport is the core/consumer side.
// Optional out_checksum is present when DIFFTEST_REGSTATE_CHECKSUM_EN is defined.
interface difftest_arch_int_reg_tracker_if #(
   parameter int NCOMMIT = 2,
   parameter int XLEN    = 64,
   parameter int CNT_W   = 16
);
   logic [NCOMMIT-1:0]      commit_valid;
   logic [NCOMMIT*5-1:0]    commit_rd;
   logic [NCOMMIT*XLEN-1:0] commit_data;
   logic [7:0]              coreid;
   logic                    out_valid;
   logic                    out_ready;
   logic [32*XLEN-1:0]      out_value;
   logic [7:0]              out_coreid;
   logic [CNT_W-1:0]        out_count;
`ifdef DIFFTEST_REGSTATE_CHECKSUM_EN
   logic [XLEN-1:0]         out_checksum;

   modport master (
      input  commit_valid, commit_rd, commit_data, coreid, out_ready,
      output out_valid, out_value, out_coreid, out_count, out_checksum
   );
   modport slave (
      output commit_valid, commit_rd, commit_data, coreid, out_ready,
      input  out_valid, out_value, out_coreid, out_count, out_checksum
   );
`else
   modport master (
      input  commit_valid, commit_rd, commit_data, coreid, out_ready,
      output out_valid, out_value, out_coreid, out_count
   );
   modport slave (
      output commit_valid, commit_rd, commit_data, coreid, out_ready,
      input  out_valid, out_value, out_coreid, out_count
   );
`endif
endinterface

// File: rtl/difftest_arch_int_reg_tracker.sv
// Producer side of the DiffTest architectural integer register-state channel.
// Keeps a 32-entry shadow of the committed integer register file and emits
// coalesced snapshots over a valid/ready handshake. While the consumer stalls,
// further commits fold into the shadow and into a saturating commit-cycle count.
// Optional feature: DIFFTEST_REGSTATE_CHECKSUM_EN adds out_checksum, the XOR of
// all 32 words of the captured snapshot.
module difftest_arch_int_reg_tracker #(
   parameter int NCOMMIT = 2,
   parameter int XLEN    = 64,
   parameter int CNT_W   = 16
) (
   input  logic                           clock,
   input  logic                           reset_n,
   difftest_arch_int_reg_tracker_if.master bus
);

   logic [XLEN-1:0]    arch_q    [32];
   logic [XLEN-1:0]    arch_next [32];
   logic [32*XLEN-1:0] snap_next;
   logic [CNT_W-1:0]   acc_q;
   logic [CNT_W-1:0]   acc_inc;
   logic               dirty_q;
   logic               any_c;
   logic               slot_free;
   logic               capture;

   // Overlay this cycle's commits on the shadow; a later port overwrites an earlier one.
   always_comb begin
      for (int k = 0; k < 32; k++) begin
         arch_next[k] = arch_q[k];
         for (int i = 0; i < NCOMMIT; i++) begin
            if (bus.commit_valid[i] && (bus.commit_rd[5*i +: 5] == 5'(k)))
               arch_next[k] = bus.commit_data[XLEN*i +: XLEN];
         end
      end
      arch_next[0] = '0;
   end

   // Flatten the updated shadow into snapshot layout.
   always_comb begin
      snap_next = '0;
      for (int k = 0; k < 32; k++)
         snap_next[XLEN*k +: XLEN] = arch_next[k];
   end

   assign any_c     = |bus.commit_valid;
   assign slot_free = !bus.out_valid || bus.out_ready;
   assign capture   = slot_free && (dirty_q || any_c);
   assign acc_inc   = (acc_q == '1) ? acc_q : acc_q + 1'b1;

   // Shadow architectural register file.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < 32; k++) arch_q[k] <= '0;
      end else begin
         for (int k = 0; k < 32; k++) arch_q[k] <= arch_next[k];
      end
   end

   // Snapshot slot, dirty flag and coalesced commit-cycle counter.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bus.out_valid  <= 1'b0;
         bus.out_value  <= '0;
         bus.out_coreid <= '0;
         bus.out_count  <= '0;
         dirty_q        <= 1'b0;
         acc_q          <= '0;
      end else if (capture) begin
         bus.out_valid  <= 1'b1;
         bus.out_value  <= snap_next;
         bus.out_coreid <= bus.coreid;
         bus.out_count  <= any_c ? acc_inc : acc_q;
         dirty_q        <= 1'b0;
         acc_q          <= '0;
      end else begin
         if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;
         if (any_c) begin
            dirty_q <= 1'b1;
            acc_q   <= acc_inc;
         end
      end
   end

`ifdef DIFFTEST_REGSTATE_CHECKSUM_EN
   logic [XLEN-1:0] csum_next;

   // XOR-fold of the snapshot being captured.
   always_comb begin
      csum_next = '0;
      for (int k = 0; k < 32; k++) csum_next = csum_next ^ arch_next[k];
   end

   // Checksum loads on the same edge as out_value and holds through stalls.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)     bus.out_checksum <= '0;
      else if (capture) bus.out_checksum <= csum_next;
   end
`endif

endmodule

// File: tb/tb_difftest_arch_int_reg_tracker.sv
// Self-checking bench for difftest_arch_int_reg_tracker. Scenario tasks plus a
// randomized run, all compared against a snapshot-level reference model.
module tb_difftest_arch_int_reg_tracker;
   localparam int NC  = 2;
   localparam int XL  = 64;
   localparam int CW  = 16;
   localparam int CW4 = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   difftest_arch_int_reg_tracker_if #(.NCOMMIT(NC), .XLEN(XL), .CNT_W(CW))  bus  ();
   difftest_arch_int_reg_tracker_if #(.NCOMMIT(NC), .XLEN(XL), .CNT_W(CW4)) bus4 ();

   difftest_arch_int_reg_tracker #(.NCOMMIT(NC), .XLEN(XL), .CNT_W(CW)) dut (
      .clock(clk), .reset_n(rst_n), .bus(bus));
   difftest_arch_int_reg_tracker #(.NCOMMIT(NC), .XLEN(XL), .CNT_W(CW4)) dut4 (
      .clock(clk), .reset_n(rst_n), .bus(bus4));

   always #5 clk = ~clk;

   // Reference model: architectural file, last delivered snapshot, commit cycles waiting.
   logic [XL-1:0] m_arch [32];
   logic [XL-1:0] m_snap [32];
   bit            m_valid;
   logic [7:0]    m_coreid;
   int            m_pending;
   int            m_count;

   function automatic logic [XL-1:0] out_reg(input int k);
      return bus.out_value[XL*k +: XL];
   endfunction

   function automatic int first_diff();
      for (int k = 0; k < 32; k++)
         if (out_reg(k) !== m_snap[k]) return k;
      return -1;
   endfunction

   function automatic logic [XL-1:0] model_xor();
      logic [XL-1:0] x = '0;
      for (int k = 0; k < 32; k++) x = x ^ m_snap[k];
      return x;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 32; k++) begin
         m_arch[k] = '0;
         m_snap[k] = '0;
      end
      m_valid = 0; m_coreid = '0; m_pending = 0; m_count = 0;
   endtask

   task automatic drive(input bit v0, input logic [4:0] rd0, input logic [XL-1:0] d0,
                        input bit v1, input logic [4:0] rd1, input logic [XL-1:0] d1);
      bus.commit_valid = {v1, v0};
      bus.commit_rd    = {rd1, rd0};
      bus.commit_data  = {d1, d0};
   endtask

   task automatic idle_inputs();
      drive(0, 5'd0, '0, 0, 5'd0, '0);
   endtask

   // Advance one clock and move the model by the spec's rules, then settle 1 time unit.
   task automatic cycle();
      logic [XL-1:0] nxt [32];
      bit any;
      @(posedge clk);
      any = 0;
      for (int k = 0; k < 32; k++) nxt[k] = m_arch[k];
      for (int i = 0; i < NC; i++) begin
         if (bus.commit_valid[i]) begin
            any = 1;
            if (bus.commit_rd[5*i +: 5] != 5'd0)
               nxt[bus.commit_rd[5*i +: 5]] = bus.commit_data[XL*i +: XL];
         end
      end
      if ((!m_valid || bus.out_ready) && (m_pending > 0 || any)) begin
         for (int k = 0; k < 32; k++) m_snap[k] = nxt[k];
         m_coreid  = bus.coreid;
         m_count   = m_pending + int'(any);
         if (m_count > (1 << CW) - 1) m_count = (1 << CW) - 1;
         m_pending = 0;
         m_valid   = 1;
      end else begin
         if (m_valid && bus.out_ready) m_valid = 0;
         if (any) m_pending++;
      end
      for (int k = 0; k < 32; k++) m_arch[k] = nxt[k];
      #1;
   endtask

   task automatic test_reset();
      checks++;
      if (bus.out_valid !== 1'b0) begin
         failures++; $display("FAIL reset_valid got=%0b exp=0", bus.out_valid);
      end
      checks++;
      if (bus.out_value !== '0) begin
         failures++; $display("FAIL reset_value got_reg1=%h exp=0", out_reg(1));
      end
      checks++;
      if (bus.out_count !== '0 || bus.out_coreid !== '0) begin
         failures++; $display("FAIL reset_count_coreid got=%0d/%0d exp=0/0", bus.out_count, bus.out_coreid);
      end
   endtask

   task automatic test_single();
      bus.out_ready = 1; bus.coreid = 8'h3C;
      drive(1, 5'd1, 64'h1234, 0, 5'd0, '0);
      cycle();
      idle_inputs();
      checks++;
      if (bus.out_valid !== 1'b1) begin
         failures++; $display("FAIL t2_valid got=%0b exp=1", bus.out_valid);
      end
      checks++;
      if (out_reg(1) !== 64'h1234 || bus.out_count !== 16'd1 || bus.out_coreid !== 8'h3C) begin
         failures++;
         $display("FAIL t2_snapshot got reg1=%h count=%0d coreid=%h exp reg1=1234 count=1 coreid=3c",
                  out_reg(1), bus.out_count, bus.out_coreid);
      end
      cycle();
      checks++;
      if (bus.out_valid !== 1'b0) begin
         failures++; $display("FAIL t2_drop got=%0b exp=0", bus.out_valid);
      end
   endtask

   task automatic test_same_rd();
      bus.out_ready = 1;
      drive(1, 5'd3, 64'h11, 1, 5'd3, 64'h22);
      cycle();
      checks++;
      if (bus.out_valid !== 1'b1 || out_reg(3) !== 64'h22) begin
         failures++; $display("FAIL t3_same_rd got valid=%0b reg3=%h exp valid=1 reg3=22", bus.out_valid, out_reg(3));
      end
      drive(1, 5'd0, 64'hFF, 0, 5'd0, '0);
      cycle();
      idle_inputs();
      checks++;
      if (bus.out_valid !== 1'b1 || out_reg(0) !== '0 || bus.out_count !== 16'd1) begin
         failures++;
         $display("FAIL t3_rd0 got valid=%0b reg0=%h count=%0d exp valid=1 reg0=0 count=1",
                  bus.out_valid, out_reg(0), bus.out_count);
      end
      checks++;
      if (out_reg(3) !== 64'h22) begin
         failures++; $display("FAIL t3_rd0_keep got reg3=%h exp=22", out_reg(3));
      end
      cycle();
   endtask

   task automatic test_coalesce();
      logic [32*XL-1:0] held;
      logic [XL-1:0]    vals [3];
      vals[0] = 64'd7; vals[1] = 64'd8; vals[2] = 64'd9;
      bus.out_ready = 0;
      drive(1, 5'd2, 64'd5, 0, 5'd0, '0);
      cycle();
      checks++;
      if (bus.out_valid !== 1'b1 || out_reg(2) !== 64'd5 || bus.out_count !== 16'd1) begin
         failures++;
         $display("FAIL t4_first got valid=%0b reg2=%0d count=%0d exp 1/5/1", bus.out_valid, out_reg(2), bus.out_count);
      end
      held = bus.out_value;
      for (int n = 0; n < 3; n++) begin
         drive(1, 5'd2, vals[n], 0, 5'd0, '0);
         bus.coreid = 8'($urandom);
         cycle();
         checks++;
         if (bus.out_value !== held || bus.out_count !== 16'd1 || bus.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL t4_hold cyc=%0d got reg2=%0d count=%0d valid=%0b exp 5/1/1",
                     n, out_reg(2), bus.out_count, bus.out_valid);
         end
      end
      idle_inputs();
      bus.out_ready = 1;
      cycle();
      checks++;
      if (bus.out_valid !== 1'b1 || out_reg(2) !== 64'd9 || bus.out_count !== 16'd3) begin
         failures++;
         $display("FAIL t4_merged got valid=%0b reg2=%0d count=%0d exp 1/9/3", bus.out_valid, out_reg(2), bus.out_count);
      end
      cycle();
      checks++;
      if (bus.out_valid !== 1'b0) begin
         failures++; $display("FAIL t4_drop got=%0b exp=0", bus.out_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0]    rd;
      logic [XL-1:0] d;
      int            diff;
      bus.out_ready = 1;
      for (int n = 0; n < 10; n++) begin
         rd = 5'($urandom_range(1, 31));
         d  = {$urandom, $urandom};
         bus.coreid = 8'($urandom);
         drive(1, rd, d, 0, 5'd0, '0);
         cycle();
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_count !== 16'd1 || out_reg(int'(rd)) !== d) begin
            failures++;
            $display("FAIL t5_b2b n=%0d got valid=%0b count=%0d reg%0d=%h exp 1/1/%h",
                     n, bus.out_valid, bus.out_count, rd, out_reg(int'(rd)), d);
         end
         diff = first_diff();
         checks++;
         if (diff >= 0) begin
            failures++; $display("FAIL t5_snapshot n=%0d reg%0d got=%h exp=%h", n, diff, out_reg(diff), m_snap[diff]);
         end
`ifdef DIFFTEST_REGSTATE_CHECKSUM_EN
         checks++;
         if (bus.out_checksum !== model_xor()) begin
            failures++; $display("FAIL t5_checksum n=%0d got=%h exp=%h", n, bus.out_checksum, model_xor());
         end
`endif
      end
      idle_inputs();
      for (int n = 0; n < 4; n++) begin
         cycle();
         checks++;
         if (bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL t5_idle n=%0d got=%0b exp=0", n, bus.out_valid);
         end
      end
   endtask

   task automatic test_reset_mid_stall();
      bus.out_ready = 0;
      drive(1, 5'd5, 64'hAA, 0, 5'd0, '0);
      cycle();
      idle_inputs();
      checks++;
      if (bus.out_valid !== 1'b1 || out_reg(5) !== 64'hAA) begin
         failures++; $display("FAIL t1_pre got valid=%0b reg5=%h exp 1/aa", bus.out_valid, out_reg(5));
      end
      #3 rst_n = 0;
      #1;
      model_reset();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_value !== '0 || bus.out_count !== '0 || bus.out_coreid !== '0) begin
         failures++;
         $display("FAIL t1_async got valid=%0b reg5=%h count=%0d exp 0/0/0", bus.out_valid, out_reg(5), bus.out_count);
      end
      #2 rst_n = 1;
      for (int n = 0; n < 3; n++) begin
         cycle();
         checks++;
         if (bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL t1_no_snapshot n=%0d got=%0b exp=0", n, bus.out_valid);
         end
      end
      bus.out_ready = 1;
      drive(1, 5'd6, 64'h66, 0, 5'd0, '0);
      cycle();
      idle_inputs();
      checks++;
      if (bus.out_valid !== 1'b1 || out_reg(5) !== '0 || out_reg(6) !== 64'h66) begin
         failures++;
         $display("FAIL t1_cleared got valid=%0b reg5=%h reg6=%h exp 1/0/66", bus.out_valid, out_reg(5), out_reg(6));
      end
      cycle();
   endtask

   task automatic test_saturation();
      bus4.out_ready = 0;
      for (int n = 0; n < 20; n++) begin
         bus4.commit_valid = 2'b01;
         bus4.commit_rd    = {5'd0, 5'd4};
         bus4.commit_data  = {64'd0, 64'(n)};
         cycle();
         if (n == 0) begin
            checks++;
            if (bus4.out_valid !== 1'b1 || bus4.out_count !== 4'd1) begin
               failures++; $display("FAIL t6_first got valid=%0b count=%0d exp 1/1", bus4.out_valid, bus4.out_count);
            end
         end
      end
      bus4.commit_valid = '0;
      bus4.out_ready    = 1;
      cycle();
      checks++;
      if (bus4.out_valid !== 1'b1 || bus4.out_count !== 4'd15 || bus4.out_value[XL*4 +: XL] !== 64'd19) begin
         failures++;
         $display("FAIL t6_sat got valid=%0b count=%0d reg4=%0d exp 1/15/19",
                  bus4.out_valid, bus4.out_count, bus4.out_value[XL*4 +: XL]);
      end
      cycle();
      checks++;
      if (bus4.out_valid !== 1'b0) begin
         failures++; $display("FAIL t6_drop got=%0b exp=0", bus4.out_valid);
      end
   endtask

   task automatic test_random();
      int diff;
      bit v0, v1;
      for (int n = 0; n < 400; n++) begin
         v0 = ($urandom_range(0, 2) == 0);
         v1 = ($urandom_range(0, 3) == 0);
         drive(v0, 5'($urandom), {$urandom, $urandom}, v1, 5'($urandom_range(0, 7)), {$urandom, $urandom});
         bus.out_ready = ($urandom_range(0, 3) != 0);
         bus.coreid    = 8'($urandom);
         cycle();
         checks++;
         if (bus.out_valid !== m_valid) begin
            failures++; $display("FAIL rand_valid n=%0d got=%0b exp=%0b", n, bus.out_valid, m_valid);
         end
         if (m_valid) begin
            diff = first_diff();
            checks++;
            if (diff >= 0) begin
               failures++; $display("FAIL rand_value n=%0d reg%0d got=%h exp=%h", n, diff, out_reg(diff), m_snap[diff]);
            end
            checks++;
            if (bus.out_coreid !== m_coreid || bus.out_count !== CW'(m_count)) begin
               failures++;
               $display("FAIL rand_meta n=%0d got coreid=%h count=%0d exp coreid=%h count=%0d",
                        n, bus.out_coreid, bus.out_count, m_coreid, m_count);
            end
`ifdef DIFFTEST_REGSTATE_CHECKSUM_EN
            checks++;
            if (bus.out_checksum !== model_xor()) begin
               failures++; $display("FAIL rand_checksum n=%0d got=%h exp=%h", n, bus.out_checksum, model_xor());
            end
`endif
         end
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      bus.coreid     = '0;
      bus.out_ready  = 1;
      bus4.commit_valid = '0;
      bus4.commit_rd    = '0;
      bus4.commit_data  = '0;
      bus4.coreid       = 8'h44;
      bus4.out_ready    = 1;
      model_reset();
      #12 rst_n = 1;
      #1;
      test_reset();
      test_single();
      test_same_rd();
      test_coalesce();
      test_back_to_back();
      test_reset_mid_stall();
      test_saturation();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
